// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard unit: controller state encoding and default address width.
// Pure declarations, no logic.
package hazard_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int CNT_W          = 2;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hz_state_t;

endpackage

// File: rtl/reg_match.sv
// Compares the EX destination register against one ID source operand, ignoring x0 and unused operands.
// Purely combinational, zero latency, no flow control.
module reg_match
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rd_i,
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic                  uses_i,
    output logic                  match_o
);

    assign match_o = uses_i && (rd_i != '0) && (rd_i == rs_i);

endmodule

// File: rtl/hazard_unit.sv
// Load-use / multi-cycle / branch hazard controller: outputs are combinational from state and inputs (0 cycles).
// Backpressure is issued upstream by dropping PCWrite/if_id_write and bubbling ID/EX via enable_nop_mux.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W        = DEF_REG_ADDR_W,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int PERF_CNT_W        = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_register_rd,
    input  logic                  ex_branch_taken,
    input  logic                  mc_busy,
    output logic                  PCWrite,
    output logic                  if_id_write,
    output logic                  if_id_clear,
    output logic                  enable_nop_mux,
    output logic                  stall_active,
    output logic [PERF_CNT_W-1:0] stall_cycles
);

    generate
        if (LOAD_STALL_CYCLES < 1 || LOAD_STALL_CYCLES > 4) begin : g_bad_stall_cycles
            $error("hazard_unit: LOAD_STALL_CYCLES must be within 1..4");
        end
    endgenerate

    // The first bubble is issued from IDLE, so the down-counter covers the remaining ones.
    localparam logic [CNT_W-1:0] CNT_INIT =
        (LOAD_STALL_CYCLES > 1) ? CNT_W'(LOAD_STALL_CYCLES - 2) : '0;

    hz_state_t              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [PERF_CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
    logic                   match_rs1, match_rs2;
    logic                   hz;

    reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs1 (
        .rd_i    (ex_register_rd),
        .rs_i    (id_rs1),
        .uses_i  (id_uses_rs1),
        .match_o (match_rs1)
    );

    reg_match #(.REG_ADDR_W(REG_ADDR_W)) u_match_rs2 (
        .rd_i    (ex_register_rd),
        .rs_i    (id_rs2),
        .uses_i  (id_uses_rs2),
        .match_o (match_rs2)
    );

    assign hz = ex_mem_read && (match_rs1 || match_rs2);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        PCWrite        = 1'b1;
        if_id_write    = 1'b1;
        if_id_clear    = 1'b0;
        enable_nop_mux = 1'b0;
        stall_active   = 1'b0;

        if (RESET) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (ex_branch_taken) begin
            // Redirect wins over everything, including an in-progress load stall.
            if_id_clear    = 1'b1;
            enable_nop_mux = 1'b1;
            state_d        = FLUSH;
        end else begin
            case (state_q)
                FLUSH: begin
                    enable_nop_mux = 1'b1;
                    state_d        = IDLE;
                end
                LOAD_STALL: begin
                    PCWrite        = 1'b0;
                    if_id_write    = 1'b0;
                    enable_nop_mux = 1'b1;
                    stall_active   = 1'b1;
                    if (!mc_busy) begin
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    if (mc_busy || hz) begin
                        PCWrite        = 1'b0;
                        if_id_write    = 1'b0;
                        enable_nop_mux = 1'b1;
                        stall_active   = 1'b1;
                    end
                    if (!mc_busy && hz && (LOAD_STALL_CYCLES > 1)) begin
                        state_d = LOAD_STALL;
                        cnt_d   = CNT_INIT;
                    end
                end
            endcase
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_active && (stall_cycles_q != {PERF_CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three parameterisations share one stimulus stream, a scoreboard queue
// holds per-cycle expectations, and a negedge monitor pops and compares them.
module tb_hazard_unit;

    logic       CLK;
    logic       RESET;
    logic [4:0] id_rs1, id_rs2, ex_register_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, mc_busy;

    logic        pcw[3], ifw[3], clr[3], nop[3], stl[3];
    logic [15:0] sc0, sc1;
    logic [1:0]  sc2;

    // Packed control vector: {PCWrite, if_id_write, if_id_clear, enable_nop_mux, stall_active}
    localparam logic [4:0] C_RUN   = 5'b11000;
    localparam logic [4:0] C_STALL = 5'b00011;
    localparam logic [4:0] C_BR    = 5'b11110;
    localparam logic [4:0] C_FLUSH = 5'b11010;

    string       q_nm[$];
    int          q_sel[$];
    logic [4:0]  q_ctl[$];
    logic [15:0] q_cnt[$];

    int checks = 0;
    int errors = 0;

    hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1), .PERF_CNT_W(16)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_register_rd(ex_register_rd), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .PCWrite(pcw[0]), .if_id_write(ifw[0]), .if_id_clear(clr[0]),
        .enable_nop_mux(nop[0]), .stall_active(stl[0]), .stall_cycles(sc0)
    );

    hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .PERF_CNT_W(16)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_register_rd(ex_register_rd), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .PCWrite(pcw[1]), .if_id_write(ifw[1]), .if_id_clear(clr[1]),
        .enable_nop_mux(nop[1]), .stall_active(stl[1]), .stall_cycles(sc1)
    );

    hazard_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3), .PERF_CNT_W(2)) u_dut2 (
        .CLK(CLK), .RESET(RESET), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_mem_read(ex_mem_read),
        .ex_register_rd(ex_register_rd), .ex_branch_taken(ex_branch_taken), .mc_busy(mc_busy),
        .PCWrite(pcw[2]), .if_id_write(ifw[2]), .if_id_clear(clr[2]),
        .enable_nop_mux(nop[2]), .stall_active(stl[2]), .stall_cycles(sc2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Monitor: outputs are sampled mid-cycle, away from the rising edge.
    string       m_nm;
    int          m_sel;
    logic [4:0]  m_ctl, a_ctl;
    logic [15:0] m_cnt, a_cnt;

    always @(negedge CLK) begin
        while (q_sel.size() > 0) begin
            m_nm  = q_nm.pop_front();
            m_sel = q_sel.pop_front();
            m_ctl = q_ctl.pop_front();
            m_cnt = q_cnt.pop_front();
            a_ctl = {pcw[m_sel], ifw[m_sel], clr[m_sel], nop[m_sel], stl[m_sel]};
            a_cnt = (m_sel == 0) ? sc0 : (m_sel == 1) ? sc1 : {14'b0, sc2};
            checks++;
            if (a_ctl !== m_ctl || a_cnt !== m_cnt) begin
                errors++;
                $display("FAIL %s dut%0d: got ctl=%b stall_cycles=%0d, expected ctl=%b stall_cycles=%0d",
                         m_nm, m_sel, a_ctl, a_cnt, m_ctl, m_cnt);
            end
        end
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    task automatic expect_out(input int sel, input string nm, input logic [4:0] ctl, input int cnt);
        q_nm.push_back(nm);
        q_sel.push_back(sel);
        q_ctl.push_back(ctl);
        q_cnt.push_back(16'(cnt));
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet();
        id_rs1 = '0; id_rs2 = '0; ex_register_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mc_busy = 1'b0;
    endtask

    task automatic load_use(input logic [4:0] rd, input logic [4:0] rs1);
        ex_mem_read = 1'b1; ex_register_rd = rd; id_rs1 = rs1; id_uses_rs1 = 1'b1;
    endtask

    task automatic do_reset();
        logic [4:0]  r_ctl;
        logic [15:0] r_cnt;
        quiet();
        RESET = 1'b1;
        step();
        for (int s = 0; s < 3; s++) begin
            r_ctl = {pcw[s], ifw[s], clr[s], nop[s], stl[s]};
            r_cnt = (s == 0) ? sc0 : (s == 1) ? sc1 : {14'b0, sc2};
            checks++;
            if (r_ctl !== C_RUN || r_cnt !== 16'd0) begin
                errors++;
                $display("FAIL reset_direct dut%0d: got ctl=%b stall_cycles=%0d, expected ctl=%b stall_cycles=0",
                         s, r_ctl, r_cnt, C_RUN);
            end
        end
        for (int s = 0; s < 3; s++) expect_out(s, "reset_state", C_RUN, 0);
        step();
        RESET = 1'b0;
    endtask

    initial begin
        quiet();
        RESET = 1'b1;
        do_reset();

        // Reset overrides every hazard source on the outputs.
        RESET = 1'b1; load_use(5'd5, 5'd5); ex_branch_taken = 1'b1; mc_busy = 1'b1;
        for (int s = 0; s < 3; s++) expect_out(s, "reset_forced", C_RUN, 0);
        step();
        do_reset();

        // Single-bubble load-use, rs1 then rs2 path.
        load_use(5'd5, 5'd5);               expect_out(0, "ls1_hz", C_STALL, 0); step();
        quiet();                            expect_out(0, "ls1_release", C_RUN, 1); step();
        expect_out(0, "ls1_hold", C_RUN, 1); step();
        ex_mem_read = 1'b1; ex_register_rd = 5'd7; id_rs2 = 5'd7; id_uses_rs2 = 1'b1;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;  expect_out(0, "ls1_rs2_hz", C_STALL, 1); step();
        quiet();                            expect_out(0, "ls1_rs2_release", C_RUN, 2); step();

        // No hazard: x0 destination, unused operand, non-load.
        do_reset();
        load_use(5'd0, 5'd0);               expect_out(0, "nohz_x0", C_RUN, 0); step();
        load_use(5'd5, 5'd5); id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b1; id_rs2 = 5'd6;
                                            expect_out(0, "nohz_unused", C_RUN, 0); step();
        load_use(5'd5, 5'd5); ex_mem_read = 1'b0;
                                            expect_out(0, "nohz_notload", C_RUN, 0); step();
        quiet();                            expect_out(0, "nohz_cnt", C_RUN, 0); step();

        // Branch, flush, re-asserted branch during flush, mc_busy in IDLE.
        do_reset();
        ex_branch_taken = 1'b1;             expect_out(0, "br_take", C_BR, 0); step();
        quiet(); load_use(5'd5, 5'd5);      expect_out(0, "br_flush_ignores_hz", C_FLUSH, 0); step();
        quiet();                            expect_out(0, "br_back_idle", C_RUN, 0); step();
        ex_branch_taken = 1'b1;             expect_out(0, "br_again", C_BR, 0); step();
        expect_out(0, "br_in_flush", C_BR, 0); step();
        quiet();                            expect_out(0, "br_flush2", C_FLUSH, 0); step();
        expect_out(0, "br_idle2", C_RUN, 0); step();
        mc_busy = 1'b1;                     expect_out(0, "mc_idle_stall", C_STALL, 0); step();
        ex_branch_taken = 1'b1;             expect_out(0, "br_over_mc", C_BR, 1); step();
        quiet();                            expect_out(0, "br_over_mc_flush", C_FLUSH, 1); step();
        expect_out(0, "br_over_mc_idle", C_RUN, 1); step();

        // Three-bubble load-use.
        do_reset();
        load_use(5'd9, 5'd9);               expect_out(1, "ls3_c0", C_STALL, 0); step();
        quiet();                            expect_out(1, "ls3_c1", C_STALL, 1); step();
        expect_out(1, "ls3_c2", C_STALL, 2); step();
        expect_out(1, "ls3_done", C_RUN, 3); step();
        expect_out(1, "ls3_hold", C_RUN, 3); step();

        // Branch aborts load stall on its second cycle.
        do_reset();
        load_use(5'd4, 5'd4);               expect_out(1, "abort_c1", C_STALL, 0); step();
        ex_branch_taken = 1'b1;             expect_out(1, "abort_c2_branch", C_BR, 1); step();
        ex_branch_taken = 1'b0;             expect_out(1, "abort_c3_flush", C_FLUSH, 1); step();
        quiet();                            expect_out(1, "abort_c4_idle", C_RUN, 1); step();

        // mc_busy freezes the load-stall counter for 4 cycles.
        do_reset();
        load_use(5'd2, 5'd2);               expect_out(1, "mc_ls_c0", C_STALL, 0); step();
        quiet(); mc_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            expect_out(1, "mc_ls_busy", C_STALL, k); step();
        end
        mc_busy = 1'b0;                     expect_out(1, "mc_ls_tail1", C_STALL, 5); step();
        expect_out(1, "mc_ls_tail2", C_STALL, 6); step();
        expect_out(1, "mc_ls_done", C_RUN, 7); step();

        // Narrow counter saturation, then reset in the middle of a load stall.
        do_reset();
        load_use(5'd8, 5'd8);               expect_out(2, "sat_c0", C_STALL, 0); step();
        quiet();                            expect_out(2, "sat_c1", C_STALL, 1); step();
        expect_out(2, "sat_c2", C_STALL, 2); step();
        mc_busy = 1'b1;                     expect_out(2, "sat_c3", C_STALL, 3); step();
        expect_out(2, "sat_c4", C_STALL, 3); step();
        quiet();                            expect_out(2, "sat_hold", C_RUN, 3); step();
        do_reset();
        load_use(5'd8, 5'd8);               expect_out(2, "rstmid_hz", C_STALL, 0); step();
        quiet(); RESET = 1'b1;              expect_out(2, "rstmid_forced", C_RUN, 1); step();
        RESET = 1'b0;                       expect_out(2, "rstmid_idle", C_RUN, 0); step();
        expect_out(2, "rstmid_idle2", C_RUN, 0); step();

        for (int w = 0; w < 4 && q_sel.size() > 0; w++) @(negedge CLK);
        #1;
        checks++;
        if (q_sel.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations never compared", q_sel.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
